alu_flags: RTL and testbench
============================

# alu_flags

Status-flag unit on the consuming end of the ALU adder's carry interface. It:
- captures `CarryOut` and the result/operands of each ALU operation into a registered C/Z/N/V flag set;
- drives the registered carry back to the adder as `CarryFlag`;
- keeps a small shadow stack for interrupt save/restore;
- evaluates branch conditions for the jump logic with a one-cycle registered result.

## Interface
Parameters:
- `DEPTH`, 2, shadow-stack entries (1–4)

Ports (reset is asynchronous, active-low; `rst_n` low forces the reset state immediately, independent of `clk`):
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `AdderOut`  in  8  adder result for the current operation
- `CarryOut`  in  1  adder carry-out
- `LHS`, `RHS`  in  8 each  operands exactly as presented to the adder (RHS already inverted for subtract)
- `upd_en`  in  1  apply the ALU result to the flags this cycle
- `upd_mask`  in  4  per-flag write enables {C,Z,N,V}, bit3=C … bit0=V
- `load_en`  in  1  load flags from `load_val`
- `load_val`  in  4  {C,Z,N,V}
- `push`, `pop`  in  1 each  shadow-stack save / restore
- `clr_err`  in  1  clear `stk_err`
- `cond_valid`  in  1  condition evaluation request
- `cond_sel`  in  4  condition code
- `CarryFlag`  out  1  registered C, to adder
- `flags`  out  4  registered {C,Z,N,V}
- `cond_ack`  out  1  result valid strobe
- `cond_true`  out  1  condition result
- `stk_full`, `stk_empty`  out  1 each  stack status
- `stk_err`  out  1  sticky stack misuse

## Operation
Reset values:
- `flags`=0000, `CarryFlag`=0
- `cond_ack`=0, `cond_true`=0
- stack pointer 0, so `stk_empty`=1 and `stk_full`=0
- `stk_err`=0

Flag computation from the ALU result:
- C = `CarryOut`
- Z = (`AdderOut`==0)
- N = `AdderOut[7]`
- V = (`LHS[7]`==`RHS[7]`) && (`AdderOut[7]`!=`LHS[7]`)

Flag write priority (highest first):
- `pop` (valid only when not empty): flags ← top of stack.
- `load_en`: flags ← `load_val`.
- `upd_en`: each flag with its mask bit set takes the computed value; the others hold.

Shadow stack:
- `push` saves the flags register value present before this edge. A flag write in the same cycle still applies.
- `push` when full: the push is dropped and `stk_err` is set.
- `pop` when empty: flags are unchanged and `stk_err` is set.
- `push` and `pop` together: both are ignored and `stk_err` is set.
- `stk_err` is sticky until `clr_err` or reset; a new error coincident with `clr_err` wins.

Conditions (`cond_sel[3]` inverts the result of `cond_sel[2:0]`):
- 0: always
- 1: C
- 2: Z
- 3: N
- 4: V
- 5: C & ~Z
- 6: N==V
- 7: ~Z & (N==V)

For example, `cond_sel`=8 means "never" and 9 means ~C.

## Timing
- Flag updates are visible on `flags` and `CarryFlag` one cycle after the `upd_en`/`load_en`/`pop` edge.
- An adder carry chain therefore sees the previous operation's carry with no combinational loop.
- Condition evaluation: `cond_valid` in cycle n produces `cond_ack`=1 and `cond_true` in cycle n+1.
- `cond_ack` is a single-cycle pulse. A request every cycle yields an ack every cycle.
- `cond_true` holds its last value when `cond_ack`=0.
- Reset asserted mid-sequence clears everything, including an in-flight ack. The first request after `rst_n` rises is honoured normally.

## Configuration
`ALU_FLAGS_FWD_EN`:
- Defined: conditions evaluate against next-state flags, i.e. after this cycle's pop/load/update per the priority above. A compare followed by a branch in the next cycle needs no stall.
- Undefined: conditions evaluate against the registered `flags`. Same-cycle updates are not seen, and the pipeline must insert one bubble.
- Latency of `cond_ack` is one cycle in both cases.

## Test plan
- Reset: hold `rst_n`=0 -> `flags`=0000, `stk_empty`=1, `cond_ack`=0; release, apply `cond_valid` with `cond_sel`=0 -> `cond_ack`=1 and `cond_true`=1 next cycle.
- Add 0x7F+0x01, `CarryOut`=0, `upd_en`, mask 1111 -> `flags`=0011 (N,V); 0xFF+0x01 with `CarryOut`=1 -> 1100 (C,Z). Drives `CarryFlag`=1.
- Masked update: mask 1000 with `CarryOut`=0 after flags=1100 -> `flags`=0100.
- Stack with `DEPTH`=2:
  - Two pushes -> `stk_full`=1; a third push -> `stk_err`=1.
  - Two pops restore in LIFO order; a third pop -> flags unchanged, `stk_err` stays 1 until `clr_err`.
- Priority: `pop`, `load_en` and `upd_en` in one cycle -> flags equal the popped value.
- Forwarding: `upd_en` that sets Z while `cond_valid` with `cond_sel`=2 in the same cycle -> `cond_true`=1 with `ALU_FLAGS_FWD_EN` defined, and the old Z without it.

Source files
------------

// File: rtl/alu_flags.sv
// ---------------------------------------------------------------------------
// alu_flags -- status-flag unit behind the ALU adder.
//
// Captures C/Z/N/V from each ALU operation into a flag register. Feeds the
// registered carry back to the adder as CarryFlag. Keeps a small shadow stack
// for interrupt save/restore. Evaluates branch conditions with a one-cycle
// registered result.
//
// Parameters:
//   DEPTH       shadow-stack entries (1..4)
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   AdderOut[7:0]       adder result of the current operation
//   CarryOut            adder carry-out
//   LHS[7:0], RHS[7:0]  adder operands (RHS already inverted for subtract)
//   upd_en, upd_mask    apply ALU result; per-flag enables {C,Z,N,V}
//   load_en, load_val   direct flag load {C,Z,N,V}
//   push, pop           shadow-stack save / restore
//   clr_err             clear sticky stk_err
//   cond_valid,cond_sel condition request and code (bit3 inverts)
//   CarryFlag           registered C, back to the adder
//   flags[3:0]          registered {C,Z,N,V}
//   cond_ack,cond_true  one-cycle result strobe and held result
//   stk_full,stk_empty  stack status
//   stk_err             sticky stack misuse
//
// Configuration macro ALU_FLAGS_FWD_EN:
//   defined   -> conditions see this cycle's next-state flags (no branch stall)
//   undefined -> conditions see the registered flags
// ---------------------------------------------------------------------------
module alu_flags #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] AdderOut,
    input  logic       CarryOut,
    input  logic [7:0] LHS,
    input  logic [7:0] RHS,
    input  logic       upd_en,
    input  logic [3:0] upd_mask,
    input  logic       load_en,
    input  logic [3:0] load_val,
    input  logic       push,
    input  logic       pop,
    input  logic       clr_err,
    input  logic       cond_valid,
    input  logic [3:0] cond_sel,
    output logic       CarryFlag,
    output logic [3:0] flags,
    output logic       cond_ack,
    output logic       cond_true,
    output logic       stk_full,
    output logic       stk_empty,
    output logic       stk_err
);

    localparam int SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

    flags_t        flags_q, flags_d;
    flags_t        alu_flags_w;
    flags_t        top_w;
    flags_t        stk_q [DEPTH];
    logic [SW-1:0] sp_q, sp_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;
    logic          ctrue_q, ctrue_d;

    logic          full_w, empty_w;
    logic          push_ok, pop_ok, misuse;
    logic          cond_res;

    // Only the sign bits of the operands matter for overflow.
    logic          unused_operand_bits;
    assign unused_operand_bits = ^{LHS[6:0], RHS[6:0]};

    function automatic logic eval_cond(input logic [3:0] sel, input flags_t f);
        logic r;
        case (sel[2:0])
            3'd0:    r = 1'b1;
            3'd1:    r = f.c;
            3'd2:    r = f.z;
            3'd3:    r = f.n;
            3'd4:    r = f.v;
            3'd5:    r = f.c & ~f.z;
            3'd6:    r = (f.n == f.v);
            default: r = ~f.z & (f.n == f.v);
        endcase
        return r ^ sel[3];
    endfunction

    // Flags implied by the current adder result.
    always_comb begin
        alu_flags_w.c = CarryOut;
        alu_flags_w.z = (AdderOut == 8'h00);
        alu_flags_w.n = AdderOut[7];
        alu_flags_w.v = (LHS[7] == RHS[7]) && (AdderOut[7] != LHS[7]);
    end

    assign full_w  = (sp_q == SW'(DEPTH));
    assign empty_w = (sp_q == '0);

    // Simultaneous push and pop cancel each other and count as misuse.
    assign push_ok = push & ~pop & ~full_w;
    assign pop_ok  = pop & ~push & ~empty_w;
    assign misuse  = (push & pop) | (push & ~pop & full_w) | (pop & ~push & empty_w);

    // Top-of-stack entry is the one just below the pointer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        top_w = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp_q == SW'(i + 1)) top_w = stk_q[i];
        end
    end

    always_comb begin
        flags_d = flags_q;
        sp_d    = sp_q;
        if (pop_ok) begin
            flags_d = top_w;
        end else if (load_en) begin
            flags_d = flags_t'(load_val);
        end else if (upd_en) begin
            flags_d = flags_t'((flags_q & ~upd_mask) | (alu_flags_w & upd_mask));
        end
        if (push_ok) sp_d = sp_q + 1'b1;
        if (pop_ok)  sp_d = sp_q - 1'b1;
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        err_d = err_q;
        if (misuse)       err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
    end

`ifdef ALU_FLAGS_FWD_EN
    assign cond_res = eval_cond(cond_sel, flags_d);
`else
    assign cond_res = eval_cond(cond_sel, flags_q);
`endif

    always_comb begin
        ack_d   = cond_valid;
        ctrue_d = cond_valid ? cond_res : ctrue_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            flags_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            ctrue_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            ctrue_q <= ctrue_d;
        end
    end

    // NOTE: stack storage is not reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && sp_q == SW'(i)) stk_q[i] <= flags_q;
        end
    end

    assign flags     = flags_q;
    assign CarryFlag = flags_q.c;
    assign cond_ack  = ack_q;
    assign cond_true = ctrue_q;
    assign stk_full  = full_w;
    assign stk_empty = empty_w;
    assign stk_err   = err_q;

endmodule

// File: tb/tb_alu_flags.sv
// ---------------------------------------------------------------------------
// tb_alu_flags -- self-checking bench for alu_flags (DEPTH=2).
// A behavioural model (integer arithmetic, queue for the stack) tracks the
// expected outputs every cycle; directed steps add fixed expected values.
// ---------------------------------------------------------------------------
module tb_alu_flags;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] AdderOut;
    logic       CarryOut;
    logic [7:0] LHS, RHS;
    logic       upd_en;
    logic [3:0] upd_mask;
    logic       load_en;
    logic [3:0] load_val;
    logic       push, pop, clr_err;
    logic       cond_valid;
    logic [3:0] cond_sel;
    logic       CarryFlag;
    logic [3:0] flags;
    logic       cond_ack, cond_true;
    logic       stk_full, stk_empty, stk_err;

    alu_flags #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .AdderOut  (AdderOut),
        .CarryOut  (CarryOut),
        .LHS       (LHS),
        .RHS       (RHS),
        .upd_en    (upd_en),
        .upd_mask  (upd_mask),
        .load_en   (load_en),
        .load_val  (load_val),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .cond_valid(cond_valid),
        .cond_sel  (cond_sel),
        .CarryFlag (CarryFlag),
        .flags     (flags),
        .cond_ack  (cond_ack),
        .cond_true (cond_true),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_err   (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic [3:0] m_stk[$];
    bit         m_err, m_ack, m_ct;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int as_signed(input logic [7:0] x);
        return (x >= 8'd128) ? int'(x) - 256 : int'(x);
    endfunction

    // Condition semantics written directly from the condition table.
    function automatic bit model_cond(input logic [3:0] sel, input logic [3:0] f);
        bit c, z, n, v, r;
        c = f[3]; z = f[2]; n = f[1]; v = f[0];
        case (int'(sel) % 8)
            0: r = 1;
            1: r = c;
            2: r = z;
            3: r = n;
            4: r = v;
            5: r = c && !z;
            6: r = (n == v);
            default: r = !z && (n == v);
        endcase
        return (sel >= 4'd8) ? !r : r;
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000;
        m_stk.delete();
        m_err = 0; m_ack = 0; m_ct = 0;
    endtask

    task automatic model_step();
        logic [3:0] calc, old, nf;
        int sl, sr, so;
        bit pop_ok, push_ok, bad;
        sl = as_signed(LHS); sr = as_signed(RHS); so = as_signed(AdderOut);
        calc[3] = CarryOut;
        calc[2] = (AdderOut == 0);
        calc[1] = (so < 0);
        calc[0] = ((sl < 0) == (sr < 0)) && ((so < 0) != (sl < 0));
        old = m_flags;
        nf  = old;
        pop_ok  = pop && !push && m_stk.size() > 0;
        push_ok = push && !pop && m_stk.size() < DEPTH;
        bad     = (push && pop) || (push && !pop && !push_ok) || (pop && !push && !pop_ok);
        if (pop_ok) nf = m_stk[$];
        else if (load_en) nf = load_val;
        else if (upd_en) begin
            for (int k = 0; k < 4; k++) if (upd_mask[k]) nf[k] = calc[k];
        end
        if (push_ok) m_stk.push_back(old);
        if (pop_ok) void'(m_stk.pop_back());
        if (bad) m_err = 1;
        else if (clr_err) m_err = 0;
        m_ack = cond_valid;
`ifdef ALU_FLAGS_FWD_EN
        if (cond_valid) m_ct = model_cond(cond_sel, nf);
`else
        if (cond_valid) m_ct = model_cond(cond_sel, old);
`endif
        m_flags = nf;
    endtask

    task automatic compare_all();
        chk("flags", flags, m_flags);
        chk("CarryFlag", {3'b0, CarryFlag}, {3'b0, m_flags[3]});
        chk("cond_ack", {3'b0, cond_ack}, {3'b0, m_ack});
        chk("cond_true", {3'b0, cond_true}, {3'b0, m_ct});
        chk("stk_full", {3'b0, stk_full}, {3'b0, (m_stk.size() == DEPTH)});
        chk("stk_empty", {3'b0, stk_empty}, {3'b0, (m_stk.size() == 0)});
        chk("stk_err", {3'b0, stk_err}, {3'b0, m_err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic idle_inputs();
        AdderOut = 8'h00; CarryOut = 1'b0; LHS = 8'h00; RHS = 8'h00;
        upd_en = 1'b0; upd_mask = 4'h0; load_en = 1'b0; load_val = 4'h0;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0; cond_valid = 1'b0; cond_sel = 4'h0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #3;
        apply_reset();
        chk("rst_flags", flags, 4'b0000);
        chk("rst_empty", {3'b0, stk_empty}, 4'd1);
        chk("rst_ack", {3'b0, cond_ack}, 4'd0);

        // First request after reset release
        cond_valid = 1'b1; cond_sel = 4'd0;
        tick();
        chk("first_ack", {3'b0, cond_ack}, 4'd1);
        chk("first_true", {3'b0, cond_true}, 4'd1);
        cond_valid = 1'b0;
        tick();
        chk("ack_pulse", {3'b0, cond_ack}, 4'd0);
        chk("true_hold", {3'b0, cond_true}, 4'd1);

        // 0x7F + 0x01 -> N,V
        AdderOut = 8'h80; CarryOut = 1'b0; LHS = 8'h7F; RHS = 8'h01;
        upd_en = 1'b1; upd_mask = 4'b1111;
        tick();
        chk("add_nv", flags, 4'b0011);
        // 0xFF + 0x01 -> C,Z
        AdderOut = 8'h00; CarryOut = 1'b1; LHS = 8'hFF; RHS = 8'h01;
        tick();
        chk("add_cz", flags, 4'b1100);
        chk("carry_fb", {3'b0, CarryFlag}, 4'd1);
        // Masked update of C only
        upd_mask = 4'b1000; CarryOut = 1'b0;
        tick();
        chk("mask_c", flags, 4'b0100);
        upd_en = 1'b0;

        // Push saves pre-edge flags while a load lands
        push = 1'b1; load_en = 1'b1; load_val = 4'b1010;
        tick();
        chk("push1_flags", flags, 4'b1010);
        load_en = 1'b0;
        tick();
        chk("push2_full", {3'b0, stk_full}, 4'd1);
        load_en = 1'b1; load_val = 4'b0001;
        tick();
        chk("push3_err", {3'b0, stk_err}, 4'd1);
        chk("push3_load", flags, 4'b0001);
        push = 1'b0;

        // pop beats load and update
        pop = 1'b1; load_val = 4'b0110; upd_en = 1'b1; upd_mask = 4'b1111;
        tick();
        chk("prio_pop", flags, 4'b1010);
        load_en = 1'b0; upd_en = 1'b0;
        tick();
        chk("pop2_lifo", flags, 4'b0100);
        chk("pop2_empty", {3'b0, stk_empty}, 4'd1);
        tick();
        chk("pop3_hold", flags, 4'b0100);
        pop = 1'b0;
        tick();
        chk("err_sticky", {3'b0, stk_err}, 4'd1);
        clr_err = 1'b1; push = 1'b1; pop = 1'b1;
        tick();
        chk("err_wins", {3'b0, stk_err}, 4'd1);
        push = 1'b0; pop = 1'b0;
        tick();
        chk("err_clr", {3'b0, stk_err}, 4'd0);
        clr_err = 1'b0;

        // Forwarding: Z set in the same cycle as a Z branch
        load_en = 1'b1; load_val = 4'b0000;
        tick();
        load_en = 1'b0;
        upd_en = 1'b1; upd_mask = 4'b0100; AdderOut = 8'h00;
        cond_valid = 1'b1; cond_sel = 4'd2;
        tick();
`ifdef ALU_FLAGS_FWD_EN
        chk("fwd_z", {3'b0, cond_true}, 4'd1);
`else
        chk("fwd_z", {3'b0, cond_true}, 4'd0);
`endif
        upd_en = 1'b0;
        cond_sel = 4'd9;   // ~C, C is 0
        tick();
        chk("not_c", {3'b0, cond_true}, 4'd1);
        cond_sel = 4'd8;   // never
        tick();
        chk("never", {3'b0, cond_true}, 4'd0);

        // Randomized traffic, with an occasional mid-sequence reset
        for (int it = 0; it < 600; it++) begin
            AdderOut   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            CarryOut   = 1'($urandom);
            LHS        = 8'($urandom);
            RHS        = 8'($urandom);
            upd_en     = ($urandom_range(0, 1) == 0);
            upd_mask   = 4'($urandom);
            load_en    = ($urandom_range(0, 7) == 0);
            load_val   = 4'($urandom);
            push       = ($urandom_range(0, 3) == 0);
            pop        = ($urandom_range(0, 3) == 0);
            clr_err    = ($urandom_range(0, 7) == 0);
            cond_valid = ($urandom_range(0, 1) == 0);
            cond_sel   = 4'($urandom);
            if ($urandom_range(0, 99) == 0) apply_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
